demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//   Inverse of the mux2..mux32 selectors: steers one N-bit input word stream to one of LANES output lanes chosen by a per-word select.
//   Each lane has a one-entry registered holding buffer with a valid/ready handshake, so a stalled lane never corrupts its neighbours.
//   Sits on the write/distribution side of the datapath: the producer issues (data, sel) and each consumer drains its own lane.
// PARAMETERS
//   N      32  data word width in bits
//   LANES  32  number of output lanes (2..32); need not be a power of two
//   SEL_W  $clog2(LANES)  select width (derived; do not override)
//   CNT_W  16  width of the saturating drop counter
// PORTS
//   clk        in   1            clock; all state updates on rising edge
//   rst_n      in   1            asynchronous, active-low reset
//   in_data    in   N            input word
//   in_sel     in   SEL_W        destination lane for in_data
//   in_valid   in   1            producer has a word
//   in_ready   out  1            block accepts the word this cycle
//   out_data   out  LANES x N    per-lane held word (unpacked array [LANES-1:0])
//   out_valid  out  LANES        per-lane word present
//   out_ready  in   LANES        per-lane consumer takes word
//   sel_err    out  1            one-cycle pulse: word dropped, in_sel >= LANES
//   drop_cnt   out  CNT_W        saturating count of dropped words
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, out_data=0, sel_err=0, drop_cnt=0; handshakes idle.
//   Accept: in_valid & in_ready at a rising edge.
//   Latency: an accepted word appears on out_data[in_sel]/out_valid[in_sel] the next cycle.
//   in_ready is combinational and equals:
//     1 if in_sel >= LANES (illegal select; the word is consumed and dropped);
//     otherwise ~out_valid[in_sel] | out_ready[in_sel].
//   in_ready may depend on in_sel and out_ready, but never on in_valid.
//   Lane state per lane k, 2 states: EMPTY (out_valid=0) and FULL (out_valid=1).
//     EMPTY -> FULL on accept to k.
//     FULL -> EMPTY on out_ready[k] with no accept to k.
//     FULL -> FULL on accept to k with out_ready[k] in the same cycle: out_data[k] takes the new word, no bubble.
//     FULL with out_ready[k]=0: out_data[k] is held stable and no accept to k occurs.
//   Only the addressed lane changes on an accept. Other lanes drain independently in the same cycle.
//   Illegal select (in_sel >= LANES, only possible if LANES is not a power of two):
//     the word is accepted and discarded; no lane changes;
//     sel_err=1 on the following cycle for exactly one cycle;
//     drop_cnt increments and saturates at 2^CNT_W-1 (no wrap).
//   out_data[k] only changes on a load to lane k, never while it is FULL and stalled.
//   No fairness or ordering across lanes; order within a lane is preserved trivially (depth 1).
//   Reset asserted mid-operation: all lanes go EMPTY at once; held words are lost.
//   Words presented during reset are not accepted.
// STRUCTURE
//   demux_pkg: typedefs word_t (logic [N-1:0]) and sel_t; constant DEFAULT_LANES=32.
//   Sub-module demux_lane (x LANES via generate):
//     one-entry buffer; ports clk, rst_n, load, d, q, valid, ready, can_load.
//   Top-level logic: select decode to the per-lane load strobes, the in_ready mux, the illegal-select path and the drop counter.
// TESTING
//   1. Reset hold-off: in_valid=1 during rst_n=0 -> in_ready=0, all out_valid=0, drop_cnt=0.
//   2. Single word: sel=5, data=32'hDEADBEEF, out_ready=0 ->
//      next cycle out_valid=32'h0000_0020, out_data[5]=DEADBEEF; it stays held over 10 stalled cycles.
//   3. Backpressure: lane 5 FULL and stalled, send sel=5 -> in_ready=0.
//      Send sel=6 instead -> accepted, lane 6 FULL, lane 5 unchanged.
//   4. Streaming: out_ready[3]=1, send 100 words to sel=3 back-to-back ->
//      in_ready=1 every cycle, all 100 words seen on lane 3 in order, no bubbles.
//   5. Illegal select: LANES=20, sel=25 -> in_ready=1, no lane changes, sel_err pulses once, drop_cnt=1.
//      Repeat with CNT_W=4 for 20 illegal words -> drop_cnt=15.
//   6. Random: 10k words with random sel and random out_ready, checked against a scoreboard model.
//      Also assert rst_n mid-stream -> all out_valid=0 within the same cycle, with no X on outputs.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the word-stream demultiplexer.
//   word_t       : default-width data word
//   sel_t        : default-width lane select
//   lane_state_t : per-lane holding-buffer state
package demux_pkg;

    localparam int unsigned DEFAULT_N     = 32;
    localparam int unsigned DEFAULT_LANES = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef logic [DEFAULT_N-1:0]              word_t;
    typedef logic [$clog2(DEFAULT_LANES)-1:0]  sel_t;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_lane.sv
// One-entry registered holding buffer for a single output lane.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   write d into the buffer this cycle (only when can_load)
//   d        in   incoming word
//   q        out  held word; changes only on load
//   valid    out  buffer holds a word
//   ready    in   consumer takes the held word this cycle
//   can_load out  buffer can accept a word this cycle (empty or draining)
module demux_lane
    import demux_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         valid,
    input  logic         ready,
    output logic         can_load
);

    lane_state_t state_q;
    lane_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LANE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LANE_EMPTY: if (load)           state_d = LANE_FULL;
            LANE_FULL:  if (!load && ready) state_d = LANE_EMPTY;
            default:                        state_d = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    assign valid    = (state_q == LANE_FULL);
    // A full lane being drained this cycle can take a replacement word with no bubble.
    assign can_load = !valid || ready;

endmodule

// File: rtl/demux_stream.sv
// Steers one N-bit word stream to one of LANES output lanes chosen per word.
// Each lane owns a one-entry holding buffer, so a stalled lane never blocks
// or corrupts the others. Selects at or above LANES are consumed and dropped.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (released synchronously upstream)
//   in_data   in   input word
//   in_sel    in   destination lane
//   in_valid  in   producer has a word
//   in_ready  out  word accepted this cycle (independent of in_valid)
//   out_data  out  per-lane held word
//   out_valid out  per-lane word present
//   out_ready in   per-lane consumer takes word
//   sel_err   out  one-cycle pulse after a word with an illegal select is dropped
//   drop_cnt  out  saturating count of dropped words
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned LANES = DEFAULT_LANES,
    parameter int unsigned SEL_W = $clog2(LANES),
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data [LANES-1:0],
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic             sel_err,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [LANES-1:0] lane_can_load;
    logic [LANES-1:0] lane_load;
    logic             sel_illegal;
    logic             sel_ready;
    logic             accept;
    logic             drop;

    // Out-of-range selects only exist when LANES is not a power of two.
    if (LANES == (1 << SEL_W)) begin : g_pow2
        always_comb sel_illegal = 1'b0;
    end else begin : g_npow2
        localparam logic [SEL_W:0] LANES_EXT = (SEL_W+1)'(LANES);
        always_comb sel_illegal = ({1'b0, in_sel} >= LANES_EXT);
    end

    always_comb begin
        sel_ready = 1'b0;
        lane_load = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_ready = lane_can_load[k];
            end
        end
        // Held low in reset so nothing is taken while the lanes are cleared.
        in_ready = rst_n && (sel_illegal || sel_ready);
        accept   = in_valid && in_ready;
        drop     = accept && sel_illegal;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_load[k] = accept && !sel_illegal && (in_sel == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(
            .N(N)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lane_load[k]),
            .d        (in_data),
            .q        (out_data[k]),
            .valid    (out_valid[k]),
            .ready    (out_ready[k]),
            .can_load (lane_can_load[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sel_err <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

    localparam int unsigned N   = 32;
    localparam int unsigned LA  = 32;
    localparam int unsigned LB  = 20;
    localparam int unsigned CWA = 16;
    localparam int unsigned CWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 32 lanes, 16-bit drop counter
    logic           rst_n;
    logic [N-1:0]   in_data;
    logic [4:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   out_data [LA-1:0];
    logic [LA-1:0]  out_valid;
    logic [LA-1:0]  out_ready;
    logic           sel_err;
    logic [CWA-1:0] drop_cnt;

    // DUT B: 20 lanes (illegal selects possible), 4-bit drop counter
    logic           b_rst_n;
    logic [N-1:0]   b_in_data;
    logic [4:0]     b_in_sel;
    logic           b_in_valid;
    logic           b_in_ready;
    logic [N-1:0]   b_out_data [LB-1:0];
    logic [LB-1:0]  b_out_valid;
    logic [LB-1:0]  b_out_ready;
    logic           b_sel_err;
    logic [CWB-1:0] b_drop_cnt;

    demux_stream #(.N(N), .LANES(LA), .CNT_W(CWA)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
        .drop_cnt(drop_cnt)
    );

    demux_stream #(.N(N), .LANES(LB), .CNT_W(CWB)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err),
        .drop_cnt(b_drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic test_reset();
        rst_n = 1'b0; b_rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 5'd5; in_data = 32'hA5A5_A5A5; out_ready = '0;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL rst_out_valid got=%h exp=0", out_valid); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got=%b exp=0", sel_err); end
        checks++; if (out_data[5] !== '0) begin errors++; $display("FAIL rst_out_data5 got=%h exp=0", out_data[5]); end
        checks++; if (b_out_valid !== '0) begin errors++; $display("FAIL rst_b_out_valid got=%h exp=0", b_out_valid); end
        in_valid = 1'b0; rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL rst_release_valid got=%h exp=0", out_valid); end
    endtask

    task automatic test_single_word();
        in_sel = 5'd5; in_data = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 32'h0000_0020) begin errors++; $display("FAIL single_valid got=%h exp=00000020", out_valid); end
        checks++; if (out_data[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", out_data[5]); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 32'h0000_0020 || out_data[5] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL single_hold cyc=%0d valid=%h data=%h exp=00000020/deadbeef", i, out_valid, out_data[5]);
            end
        end
    endtask

    task automatic test_backpressure();
        in_sel = 5'd5; in_data = 32'h1111_2222; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled_ready got=%b exp=0", in_ready); end
        in_sel = 5'd6; in_data = 32'h1234_5678;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 32'h0000_0060) begin errors++; $display("FAIL bp_valid got=%h exp=00000060", out_valid); end
        checks++; if (out_data[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_lane5 got=%h exp=deadbeef", out_data[5]); end
        checks++; if (out_data[6] !== 32'h1234_5678) begin errors++; $display("FAIL bp_lane6 got=%h exp=12345678", out_data[6]); end
        out_ready = '1;
        @(posedge clk); #1;
        out_ready = '0;
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL bp_drain got=%h exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [N-1:0] words[$];
        out_ready = '0; out_ready[3] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = $urandom; words.push_back(in_data);
            in_sel = 5'd3; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready word=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 32'h0000_0008 || out_data[3] !== words[i]) begin
                errors++; $display("FAIL stream_word word=%0d valid=%h data=%h exp=00000008/%h", i, out_valid, out_data[3], words[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL stream_drain got=%h exp=0", out_valid); end
        out_ready = '0;
    endtask

    task automatic test_illegal_select();
        b_in_sel = 5'd25; b_in_data = 32'hBAD0_0001; b_in_valid = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%b exp=1", b_in_ready); end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== '0) begin errors++; $display("FAIL ill_no_lane got=%h exp=0", b_out_valid); end
        checks++; if (b_sel_err !== 1'b1) begin errors++; $display("FAIL ill_err_pulse got=%b exp=1", b_sel_err); end
        checks++; if (b_drop_cnt !== 4'd1) begin errors++; $display("FAIL ill_cnt1 got=%0d exp=1", b_drop_cnt); end
        @(posedge clk); #1;
        checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL ill_err_once got=%b exp=0", b_sel_err); end
        for (int i = 0; i < 20; i++) begin
            b_in_sel = 5'(LB + (i % 12)); b_in_data = $urandom; b_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b_drop_cnt !== 4'd15) begin errors++; $display("FAIL ill_saturate got=%0d exp=15", b_drop_cnt); end
        checks++; if (b_out_valid !== '0) begin errors++; $display("FAIL ill_no_lane2 got=%h exp=0", b_out_valid); end
    endtask

    task automatic test_random();
        bit           mv [32];
        logic [N-1:0] md [32];
        int           mcnt;
        bit           merr;
        bit           exp_rdy;
        bit           acc;
        bit           bad;
        int           sel;
        logic [LB-1:0] ev;

        b_in_valid = 1'b0; b_rst_n = 1'b0;
        #1; b_rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin mv[k] = 1'b0; md[k] = '0; end
        mcnt = 0; merr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                b_in_valid = 1'b1; b_in_sel = 5'd2; b_in_data = $urandom;
                b_rst_n = 1'b0;
                #1;
                checks++; if (b_out_valid !== '0) begin errors++; $display("FAIL mid_rst_valid got=%h exp=0", b_out_valid); end
                checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", b_in_ready); end
                bad = $isunknown({b_out_valid, b_sel_err, b_drop_cnt, b_in_ready});
                for (int k = 0; k < LB; k++) if ($isunknown(b_out_data[k])) bad = 1'b1;
                checks++; if (bad) begin errors++; $display("FAIL mid_rst_x got=unknown exp=known"); end
                for (int k = 0; k < 32; k++) begin mv[k] = 1'b0; md[k] = '0; end
                mcnt = 0; merr = 1'b0;
                @(posedge clk); #1;
                checks++; if (b_out_valid !== '0) begin errors++; $display("FAIL mid_rst_hold got=%h exp=0", b_out_valid); end
                b_rst_n = 1'b1;
            end

            b_in_valid  = ($urandom_range(0, 3) != 0);
            sel         = ($urandom_range(0, 9) == 0) ? int'($urandom_range(LB, 31)) : int'($urandom_range(0, LB-1));
            b_in_sel    = 5'(sel);
            b_in_data   = $urandom;
            b_out_ready = LB'($urandom);
            #1;
            exp_rdy = (sel >= int'(LB)) || !mv[sel] || b_out_ready[sel];
            checks++;
            if (b_in_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready cyc=%0d sel=%0d got=%b exp=%b", i, sel, b_in_ready, exp_rdy);
            end
            acc = b_in_valid && exp_rdy;

            @(posedge clk); #1;
            for (int k = 0; k < int'(LB); k++) begin
                if (acc && sel == k) begin mv[k] = 1'b1; md[k] = b_in_data; end
                else if (b_out_ready[k]) mv[k] = 1'b0;
            end
            merr = acc && (sel >= int'(LB));
            if (merr && mcnt < 15) mcnt++;

            for (int k = 0; k < int'(LB); k++) ev[k] = mv[k];
            checks++;
            if (b_out_valid !== ev) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%h exp=%h", i, b_out_valid, ev);
            end
            bad = 1'b0;
            for (int k = 0; k < int'(LB); k++) if (b_out_data[k] !== md[k]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL rnd_data cyc=%0d sel=%0d got=%h exp=%h", i, sel, b_out_data[sel % LB], md[sel % LB]);
            end
            checks++;
            if (b_sel_err !== merr || b_drop_cnt !== 4'(mcnt)) begin
                errors++; $display("FAIL rnd_drop cyc=%0d err=%b cnt=%0d exp_err=%b exp_cnt=%0d", i, b_sel_err, b_drop_cnt, merr, mcnt);
            end
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_streaming();
        test_illegal_select();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
